// File: rtl/flappy_game_ctrl.sv
// rtl/flappy_game_ctrl.sv - frame-rate IDLE/PLAY/OVER sequencer owning bird, tube and score state
module flappy_game_ctrl #(
    parameter int TUBE_SPEED   = 2,
    parameter int TUBE_PITCH   = 220,
    parameter int GRAVITY      = 1,
    parameter int FLAP_VEL     = 7,
    parameter int MAX_FALL     = 8,
    parameter int BIRD_START_Y = 240,
    parameter int HOLD_FRAMES  = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       flap,
    input  logic       loose,
    output logic [9:0] tube1_x,
    output logic [9:0] tube2_x,
    output logic [9:0] tube3_x,
    output logic [9:0] tube1_y,
    output logic [9:0] tube2_y,
    output logic [9:0] tube3_y,
    output logic [9:0] bird_y,
    output logic [7:0] score,
    output logic [1:0] state,
    output logic       game_over
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_OVER = 2'b10
    } state_t;

    localparam logic [9:0]        SPEED_X  = 10'(TUBE_SPEED);
    localparam logic [9:0]        WRAP_X   = 10'(3 * TUBE_PITCH - TUBE_SPEED);
    localparam logic [9:0]        PASS_X   = 10'd125;
    localparam logic [9:0]        START_Y  = 10'(BIRD_START_Y);
    localparam logic signed [5:0] FLAP_V   = 6'(-FLAP_VEL);
    localparam logic signed [5:0] MAX_V    = 6'(MAX_FALL);
    localparam logic signed [5:0] GRAV_V   = 6'(GRAVITY);
    localparam logic [6:0]        HOLD_V   = 7'(HOLD_FRAMES);
    localparam logic [29:0]       TX_RESET = {10'd840, 10'd620, 10'd400};
    localparam logic [29:0]       TY_RESET = {10'd240, 10'd190, 10'd140};

    state_t            state_q, state_d;
    logic [2:0][9:0]   tx_q, tx_d, ty_q, ty_d;
    logic [9:0]        bird_y_q, bird_y_d;
    logic signed [5:0] vel_q, vel_d;
    logic [7:0]        score_q, score_d;
    logic [6:0]        hold_q, hold_d;
    logic              flap_s1_q, flap_s1_d, flap_s2_q, flap_s2_d, flap_s3_q, flap_s3_d;
    logic              flap_pend_q, flap_pend_d;
    logic [15:0]       lfsr_q, lfsr_d;

    logic              flap_now;
    logic signed [10:0] bird_sum;
    logic signed [5:0] vel_inc;
    logic [1:0]        passes;
    logic [8:0]        score_sum;

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        ty_d        = ty_q;
        bird_y_d    = bird_y_q;
        vel_d       = vel_q;
        score_d     = score_q;
        hold_d      = hold_q;
        flap_s1_d   = flap;
        flap_s2_d   = flap_s1_q;
        flap_s3_d   = flap_s2_q;
        passes      = 2'd0;
        bird_sum    = {1'b0, bird_y_q} + {{5{vel_q[5]}}, vel_q};
        vel_inc     = vel_q + GRAV_V;
        lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        // A rising edge seen in the tick cycle counts as pending for that tick.
        flap_now    = flap_pend_q | (flap_s2_q & ~flap_s3_q);
        flap_pend_d = frame_tick ? 1'b0 : flap_now;

        if (frame_tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (flap_now) begin
                        state_d = S_PLAY;
                        score_d = 8'd0;
                        vel_d   = FLAP_V;
                    end
                end
                S_PLAY: begin
                    if (loose) begin
                        state_d = S_OVER;
                        hold_d  = 7'd0;
                    end else begin
                        if (bird_sum < 11'sd0)        bird_y_d = 10'd0;
                        else if (bird_sum > 11'sd455) bird_y_d = 10'd455;
                        else                          bird_y_d = bird_sum[9:0];
                        if (flap_now)            vel_d = FLAP_V;
                        else if (vel_inc > MAX_V) vel_d = MAX_V;
                        else                     vel_d = vel_inc;
                        for (int i = 0; i < 3; i++) begin
                            if (tx_q[i] < SPEED_X) begin
                                tx_d[i] = tx_q[i] + WRAP_X;
                                ty_d[i] = 10'd40 + {2'b00, lfsr_q[7:0]};
                            end else begin
                                tx_d[i] = tx_q[i] - SPEED_X;
                            end
                            if (tx_q[i] > PASS_X && tx_d[i] <= PASS_X) passes = passes + 2'd1;
                        end
                        score_sum = {1'b0, score_q} + {7'd0, passes};
                        score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
                    end
                end
                S_OVER: begin
                    if (hold_q < HOLD_V) begin
                        hold_d = hold_q + 7'd1;
                    end else if (flap_now) begin
                        state_d  = S_IDLE;
                        tx_d     = TX_RESET;
                        ty_d     = TY_RESET;
                        bird_y_d = START_Y;
                        vel_d    = 6'sd0;
                        hold_d   = 7'd0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        score_sum = {1'b0, score_q} + {7'd0, passes};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tx_q        <= TX_RESET;
            ty_q        <= TY_RESET;
            bird_y_q    <= START_Y;
            vel_q       <= 6'sd0;
            score_q     <= 8'd0;
            hold_q      <= 7'd0;
            flap_s1_q   <= 1'b0;
            flap_s2_q   <= 1'b0;
            flap_s3_q   <= 1'b0;
            flap_pend_q <= 1'b0;
            lfsr_q      <= 16'hACE1;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            ty_q        <= ty_d;
            bird_y_q    <= bird_y_d;
            vel_q       <= vel_d;
            score_q     <= score_d;
            hold_q      <= hold_d;
            flap_s1_q   <= flap_s1_d;
            flap_s2_q   <= flap_s2_d;
            flap_s3_q   <= flap_s3_d;
            flap_pend_q <= flap_pend_d;
            lfsr_q      <= lfsr_d;
        end
    end

    assign tube1_x   = tx_q[0];
    assign tube2_x   = tx_q[1];
    assign tube3_x   = tx_q[2];
    assign tube1_y   = ty_q[0];
    assign tube2_y   = ty_q[1];
    assign tube3_y   = ty_q[2];
    assign bird_y    = bird_y_q;
    assign score     = score_q;
    assign state     = state_q;
    assign game_over = (state_q == S_OVER);

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// tb/tb_flappy_game_ctrl.sv - scoreboard bench for flappy_game_ctrl
module tb_flappy_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, frame_tick, flap, loose, loose_en;
    logic [9:0] tube1_x, tube2_x, tube3_x, tube1_y, tube2_y, tube3_y, bird_y;
    logic [7:0] score;
    logic [1:0] state;
    logic       game_over;

    always #5 clk = ~clk;

    assign loose = loose_en && (({1'b0, bird_y} + 11'd25) >= 11'd479);

    flappy_game_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .flap(flap), .loose(loose),
        .tube1_x(tube1_x), .tube2_x(tube2_x), .tube3_x(tube3_x),
        .tube1_y(tube1_y), .tube2_y(tube2_y), .tube3_y(tube3_y),
        .bird_y(bird_y), .score(score), .state(state), .game_over(game_over)
    );

    // chk bits: 0 state, 1 game_over, 2 t1x, 3 t2x, 4 t3x, 5 t1y exact, 6 bird_y, 7 score, 8 t1y range
    typedef struct {
        string      nm;
        logic [8:0] chk;
        logic [1:0] st;
        logic       go;
        logic [9:0] t1x, t2x, t3x, t1y, by;
        logic [7:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic push(input string nm, input logic [8:0] chk, input logic [1:0] st, input logic go,
                        input logic [9:0] t1x, input logic [9:0] t2x, input logic [9:0] t3x,
                        input logic [9:0] t1y, input logic [9:0] by, input logic [7:0] sc);
        exp_t e;
        e.nm = nm; e.chk = chk; e.st = st; e.go = go; e.t1x = t1x; e.t2x = t2x;
        e.t3x = t3x; e.t1y = t1y; e.by = by; e.sc = sc;
        exp_q.push_back(e);
    endtask

    task automatic cmp(input string nm, input string f, input logic [9:0] act, input logic [9:0] exp_v);
        n_total++;
        if (act !== exp_v) $display("FAIL %s.%s actual=%0d expected=%0d", nm, f, act, exp_v);
        else n_pass++;
    endtask

    initial begin
        exp_t e;
        forever begin
            wait (exp_q.size() != 0);
            #1;
            e = exp_q.pop_front();
            if (e.chk[0]) cmp(e.nm, "state", {8'd0, state}, {8'd0, e.st});
            if (e.chk[1]) cmp(e.nm, "game_over", {9'd0, game_over}, {9'd0, e.go});
            if (e.chk[2]) cmp(e.nm, "tube1_x", tube1_x, e.t1x);
            if (e.chk[3]) cmp(e.nm, "tube2_x", tube2_x, e.t2x);
            if (e.chk[4]) cmp(e.nm, "tube3_x", tube3_x, e.t3x);
            if (e.chk[5]) cmp(e.nm, "tube1_y", tube1_y, e.t1y);
            if (e.chk[6]) cmp(e.nm, "bird_y", bird_y, e.by);
            if (e.chk[7]) cmp(e.nm, "score", {2'd0, score}, {2'd0, e.sc});
            if (e.chk[8]) begin
                n_total++;
                if ($isunknown(tube1_y) || tube1_y < 10'd40 || tube1_y > 10'd295)
                    $display("FAIL %s.tube1_y_range actual=%0d required=40..295", e.nm, tube1_y);
                else n_pass++;
            end
        end
    end

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) frame_tick = 1'b1;
            @(negedge clk) frame_tick = 1'b0;
        end
    endtask

    task automatic flap_press();
        @(negedge clk) flap = 1'b1;
        repeat (4) @(negedge clk);
        flap = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; flap = 1'b0; loose_en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push("reset", 9'h0FF, 2'd0, 1'b0, 10'd400, 10'd620, 10'd840, 10'd140, 10'd240, 8'd0);
        ticks(3);
        push("idle_hold", 9'h0FF, 2'd0, 1'b0, 10'd400, 10'd620, 10'd840, 10'd140, 10'd240, 8'd0);

        // Game 1: flap dynamics, floor clamp, loose -> OVER, hold behaviour.
        loose_en = 1'b1;
        flap_press();
        ticks(1);
        push("start", 9'h0C5, 2'd1, 1'b0, 10'd400, 10'd0, 10'd0, 10'd0, 10'd240, 8'd0);
        ticks(1);
        push("rise1", 9'h0C5, 2'd1, 1'b0, 10'd398, 10'd0, 10'd0, 10'd0, 10'd233, 8'd0);
        ticks(1);
        push("rise2", 9'h0C5, 2'd1, 1'b0, 10'd396, 10'd0, 10'd0, 10'd0, 10'd227, 8'd0);
        ticks(40);
        push("clamp", 9'h0C5, 2'd1, 1'b0, 10'd316, 10'd0, 10'd0, 10'd0, 10'd455, 8'd0);
        ticks(1);
        push("over_entry", 9'h0C7, 2'd2, 1'b1, 10'd316, 10'd0, 10'd0, 10'd0, 10'd455, 8'd0);
        ticks(9);
        flap_press();
        ticks(1);
        push("over_early_flap", 9'h047, 2'd2, 1'b1, 10'd316, 10'd0, 10'd0, 10'd0, 10'd455, 8'd0);
        ticks(50);
        ticks(1);
        push("over_discard", 9'h047, 2'd2, 1'b1, 10'd316, 10'd0, 10'd0, 10'd0, 10'd455, 8'd0);
        flap_press();
        ticks(1);
        push("restart1", 9'h0FF, 2'd0, 1'b0, 10'd400, 10'd620, 10'd840, 10'd140, 10'd240, 8'd0);

        // Game 2: long run with tube motion, scoring and wrap.
        loose_en = 1'b0;
        flap_press();
        ticks(1);
        push("play2_start", 9'h0C5, 2'd1, 1'b0, 10'd400, 10'd0, 10'd0, 10'd0, 10'd240, 8'd0);
        ticks(63);
        push("t63", 9'h0C5, 2'd1, 1'b0, 10'd274, 10'd0, 10'd0, 10'd0, 10'd455, 8'd0);
        ticks(74);
        push("t137", 9'h084, 2'd0, 1'b0, 10'd126, 10'd0, 10'd0, 10'd0, 10'd0, 8'd0);
        ticks(1);
        push("t138", 9'h09C, 2'd0, 1'b0, 10'd124, 10'd344, 10'd564, 10'd0, 10'd0, 8'd1);
        ticks(61);
        push("t199", 9'h004, 2'd0, 1'b0, 10'd2, 10'd0, 10'd0, 10'd0, 10'd0, 8'd0);
        ticks(1);
        push("t200", 9'h004, 2'd0, 1'b0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 8'd0);
        ticks(1);
        push("t201_wrap", 9'h19C, 2'd0, 1'b0, 10'd658, 10'd218, 10'd438, 10'd0, 10'd0, 8'd1);
        loose_en = 1'b1;
        ticks(1);
        push("over2", 9'h0C7, 2'd2, 1'b1, 10'd658, 10'd0, 10'd0, 10'd0, 10'd455, 8'd1);
        ticks(60);
        flap_press();
        ticks(1);
        push("restart2", 9'h0FF, 2'd0, 1'b0, 10'd400, 10'd620, 10'd840, 10'd140, 10'd240, 8'd1);
        loose_en = 1'b0;
        flap_press();
        ticks(1);
        push("play3_start", 9'h0C5, 2'd1, 1'b0, 10'd400, 10'd0, 10'd0, 10'd0, 10'd240, 8'd0);
        ticks(2);
        push("play3_run", 9'h0C4, 2'd0, 1'b0, 10'd396, 10'd0, 10'd0, 10'd0, 10'd227, 8'd0);

        // Reset lands between clock edges; the check runs before the next posedge.
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 push("async_rst", 9'h0FF, 2'd0, 1'b0, 10'd400, 10'd620, 10'd840, 10'd140, 10'd240, 8'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
